// File: rtl/rvfi_check_scheduler.sv
// ---------------------------------------------------------------------------
// rvfi_check_scheduler
//   Decides when the per-instruction checker's 'check' input fires and on
//   which RVFI retire channel. It sits between the core's RVFI bus and the
//   checker.
//
//   Run flow: WARMUP -> ARMED -> DONE.
//   - WARMUP waits until the cycle counter reaches CHECK_CYCLE-1 with enable.
//   - ARMED lets SKIP retirements pass, then pulses check once, in the same
//     cycle as the retirement, on the lowest valid channel.
//   - DONE is sticky until reset.
//   If the cycle counter saturates while ARMED, the run ends with timeout.
//
// Ports
//   i_clock                in   system clock
//   i_reset                in   asynchronous active-high reset
//   i_enable               in   0 freezes arming/skip progress (cycle still counts)
//   i_rvfi_valid  [NRET]   in   per-channel retire strobe
//   i_rvfi_trap   [NRET]   in   per-channel trap flag
//   i_rvfi_rollback_valid  in   rollback of uncommitted retirements
//   o_check                out  check pulse (combinational)
//   o_check_onehot[NRET]   out  channel being checked, 0 when o_check=0
//   o_check_trap           out  trap flag of the checked channel
//   o_cycle      [CYCLEW]  out  saturating cycles since reset release
//   o_retire_count[CYCLEW] out  saturating count of all retirements
//   o_done                 out  run finished (checked or timed out)
//   o_timeout              out  cycle counter saturated while ARMED
// ---------------------------------------------------------------------------
module rvfi_check_scheduler #(
  parameter int NRET        = 1,
  parameter int CYCLEW      = 8,
  parameter int CHECK_CYCLE = 20,
  parameter int SKIP        = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [NRET-1:0]   i_rvfi_valid,
  input  logic [NRET-1:0]   i_rvfi_trap,
  input  logic              i_rvfi_rollback_valid,
  output logic              o_check,
  output logic [NRET-1:0]   o_check_onehot,
  output logic              o_check_trap,
  output logic [CYCLEW-1:0] o_cycle,
  output logic [CYCLEW-1:0] o_retire_count,
  output logic              o_done,
  output logic              o_timeout
);

  localparam int SKIPW = (SKIP < 1) ? 1 : $clog2(SKIP + 1);
  localparam int CMAX  = (1 << CYCLEW) - 1;

  typedef enum logic [1:0] {
    S_WARMUP = 2'd0,
    S_ARMED  = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CYCLEW-1:0] r_cycle;
  logic [CYCLEW-1:0] r_retire_count;
  logic [SKIPW-1:0]  r_skip;
  logic [SKIPW-1:0]  w_skip_next;
  logic              r_timeout;
  logic              w_timeout_next;

  int                w_pop;
  int                w_retire_sum;
  int                w_skip_sum;
  logic              w_eligible;
  logic              w_skip_pending;
  logic              w_fire;
  logic [NRET-1:0]   w_lowest;

  // Number of channels retiring this cycle.
  always_comb begin
    w_pop = 0;
    for (int i = 0; i < NRET; i++) begin
      w_pop = w_pop + (i_rvfi_valid[i] ? 1 : 0);
    end
  end

  // Isolate the lowest set bit: x & -x.
  assign w_lowest       = i_rvfi_valid & (~i_rvfi_valid + NRET'(1));
  assign w_eligible     = i_enable & (|i_rvfi_valid) & ~i_rvfi_rollback_valid;
  assign w_skip_pending = (int'(r_skip) < SKIP);
  assign w_fire         = (r_state == S_ARMED) & w_eligible & ~w_skip_pending;
  assign w_retire_sum   = int'(r_retire_count) + w_pop;

  always_comb begin
    w_state_next   = r_state;
    w_skip_next    = r_skip;
    w_timeout_next = r_timeout;
    w_skip_sum     = int'(r_skip) + w_pop;
    case (r_state)
      S_WARMUP: begin
        if (i_enable && (int'(r_cycle) >= CHECK_CYCLE - 1)) begin
          w_state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        // Rollback outranks both enable and retirement.
        if (i_rvfi_rollback_valid) begin
          w_skip_next = '0;
        end else if (i_enable && (|i_rvfi_valid)) begin
          if (w_skip_pending) begin
            w_skip_next = SKIPW'((w_skip_sum > SKIP) ? SKIP : w_skip_sum);
          end else begin
            w_state_next = S_DONE;
          end
        end
        // Saturated cycle counter with no check this cycle ends the run.
        if (!w_fire && i_enable && (int'(r_cycle) == CMAX)) begin
          w_state_next   = S_DONE;
          w_timeout_next = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_WARMUP;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_WARMUP;
      r_cycle        <= '0;
      r_retire_count <= '0;
      r_skip         <= '0;
      r_timeout      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_skip    <= w_skip_next;
      r_timeout <= w_timeout_next;
      if (r_cycle != '1) begin
        r_cycle <= r_cycle + CYCLEW'(1);
      end
      r_retire_count <= (w_retire_sum > CMAX) ? '1 : CYCLEW'(w_retire_sum);
    end
  end

  // Check is gated by reset directly so it drops the instant reset rises.
  assign o_check        = w_fire & ~i_reset;
  assign o_check_onehot = o_check ? w_lowest : '0;
  assign o_check_trap   = o_check & (|(i_rvfi_trap & w_lowest));
  assign o_cycle        = r_cycle;
  assign o_retire_count = r_retire_count;
  assign o_done         = (r_state == S_DONE);
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_rvfi_check_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rvfi_check_scheduler
//   Directed bench for rvfi_check_scheduler using three instances:
//   A: NRET=2, CYCLEW=8, CHECK_CYCLE=20, SKIP=0
//   B: NRET=1, CYCLEW=8, CHECK_CYCLE=4,  SKIP=3
//   C: NRET=1, CYCLEW=5, CHECK_CYCLE=20, SKIP=0
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. Cycle index k equals the expected o_cycle value.
// ---------------------------------------------------------------------------
module tb_rvfi_check_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A
  logic       a_rst, a_en, a_rb;
  logic [1:0] a_valid, a_trap;
  logic       a_check, a_ctrap, a_done, a_tmo;
  logic [1:0] a_onehot;
  logic [7:0] a_cycle, a_rcnt;

  // Instance B
  logic       b_rst, b_en, b_rb;
  logic [0:0] b_valid, b_trap;
  logic       b_check, b_ctrap, b_done, b_tmo;
  logic [0:0] b_onehot;
  logic [7:0] b_cycle, b_rcnt;

  // Instance C
  logic       c_rst, c_en, c_rb;
  logic [0:0] c_valid, c_trap;
  logic       c_check, c_ctrap, c_done, c_tmo;
  logic [0:0] c_onehot;
  logic [4:0] c_cycle, c_rcnt;

  rvfi_check_scheduler #(.NRET(2), .CYCLEW(8), .CHECK_CYCLE(20), .SKIP(0)) dut_a (
    .i_clock(clk), .i_reset(a_rst), .i_enable(a_en),
    .i_rvfi_valid(a_valid), .i_rvfi_trap(a_trap), .i_rvfi_rollback_valid(a_rb),
    .o_check(a_check), .o_check_onehot(a_onehot), .o_check_trap(a_ctrap),
    .o_cycle(a_cycle), .o_retire_count(a_rcnt), .o_done(a_done), .o_timeout(a_tmo)
  );

  rvfi_check_scheduler #(.NRET(1), .CYCLEW(8), .CHECK_CYCLE(4), .SKIP(3)) dut_b (
    .i_clock(clk), .i_reset(b_rst), .i_enable(b_en),
    .i_rvfi_valid(b_valid), .i_rvfi_trap(b_trap), .i_rvfi_rollback_valid(b_rb),
    .o_check(b_check), .o_check_onehot(b_onehot), .o_check_trap(b_ctrap),
    .o_cycle(b_cycle), .o_retire_count(b_rcnt), .o_done(b_done), .o_timeout(b_tmo)
  );

  rvfi_check_scheduler #(.NRET(1), .CYCLEW(5), .CHECK_CYCLE(20), .SKIP(0)) dut_c (
    .i_clock(clk), .i_reset(c_rst), .i_enable(c_en),
    .i_rvfi_valid(c_valid), .i_rvfi_trap(c_trap), .i_rvfi_rollback_valid(c_rb),
    .o_check(c_check), .o_check_onehot(c_onehot), .o_check_trap(c_ctrap),
    .o_cycle(c_cycle), .o_retire_count(c_rcnt), .o_done(c_done), .o_timeout(c_tmo)
  );

  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_a(input logic en);
    a_rst = 1'b1; a_en = en; a_valid = 2'b00; a_trap = 2'b00; a_rb = 1'b0;
    advance(1);
    a_rst = 1'b0;
  endtask

  task automatic reset_b();
    b_rst = 1'b1; b_en = 1'b1; b_valid = 1'b0; b_trap = 1'b0; b_rb = 1'b0;
    advance(1);
    b_rst = 1'b0;
  endtask

  task automatic reset_c();
    c_rst = 1'b1; c_en = 1'b1; c_valid = 1'b0; c_trap = 1'b0; c_rb = 1'b0;
    advance(1);
    c_rst = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_en = 1'b1; a_valid = 2'b11; a_trap = 2'b11; a_rb = 1'b0;
    @(negedge clk);
    total++; if (a_check !== 1'b0) begin bad++; $display("FAIL rst_check got=%b exp=0", a_check); end
    total++; if (a_cycle !== 8'd0) begin bad++; $display("FAIL rst_cycle got=%0d exp=0", a_cycle); end
    total++; if (a_rcnt !== 8'd0) begin bad++; $display("FAIL rst_rcnt got=%0d exp=0", a_rcnt); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", a_done); end
    total++; if (a_tmo !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", a_tmo); end
    total++; if (a_onehot !== 2'b00) begin bad++; $display("FAIL rst_onehot got=%b exp=00", a_onehot); end
    $display("test_reset done");
  endtask

  // Single channel retiring every cycle from release: check exactly at cycle 20.
  task automatic run_a_scenario1(input string tag);
    logic e_chk, e_done;
    for (int k = 0; k <= 24; k++) begin
      a_valid = 2'b01;
      @(negedge clk);
      e_chk  = (k == 20);
      e_done = (k > 20);
      total++; if (a_cycle !== 8'(k)) begin bad++; $display("FAIL %s_cycle k=%0d got=%0d exp=%0d", tag, k, a_cycle, k); end
      total++; if (a_check !== e_chk) begin bad++; $display("FAIL %s_check k=%0d got=%b exp=%b", tag, k, a_check, e_chk); end
      total++; if (a_done !== e_done) begin bad++; $display("FAIL %s_done k=%0d got=%b exp=%b", tag, k, a_done, e_done); end
      total++; if (a_rcnt !== 8'(k)) begin bad++; $display("FAIL %s_rcnt k=%0d got=%0d exp=%0d", tag, k, a_rcnt, k); end
      if (k == 20) begin
        total++; if (a_onehot !== 2'b01) begin bad++; $display("FAIL %s_onehot got=%b exp=01", tag, a_onehot); end
      end
      @(posedge clk); #1;
    end
    $display("%s scenario done", tag);
  endtask

  task automatic test_single_channel();
    reset_a(1'b1);
    run_a_scenario1("s1");
  endtask

  task automatic test_reset_mid_check();
    reset_a(1'b1);
    a_valid = 2'b01;
    advance(20);
    @(negedge clk);
    total++; if (a_check !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", a_check); end
    a_rst = 1'b1;
    #1;
    total++; if (a_check !== 1'b0) begin bad++; $display("FAIL midrst_check got=%b exp=0", a_check); end
    total++; if (a_cycle !== 8'd0) begin bad++; $display("FAIL midrst_cycle got=%0d exp=0", a_cycle); end
    total++; if (a_rcnt !== 8'd0) begin bad++; $display("FAIL midrst_rcnt got=%0d exp=0", a_rcnt); end
    @(posedge clk); #1;
    a_rst = 1'b0;
    run_a_scenario1("midrst");
  endtask

  // Enable low through cycle 24 keeps WARMUP; arming happens at the edge
  // closing cycle 25, so check fires at cycle 26.
  task automatic test_enable();
    logic e_chk;
    reset_a(1'b0);
    for (int k = 0; k <= 27; k++) begin
      a_en = (k >= 25);
      a_valid = 2'b01;
      @(negedge clk);
      e_chk = (k == 26);
      total++; if (a_check !== e_chk) begin bad++; $display("FAIL en_check k=%0d got=%b exp=%b", k, a_check, e_chk); end
      total++; if (a_rcnt !== 8'(k)) begin bad++; $display("FAIL en_rcnt k=%0d got=%0d exp=%0d", k, a_rcnt, k); end
      @(posedge clk); #1;
    end
    $display("test_enable done");
  endtask

  task automatic test_arbitration();
    reset_a(1'b1);
    advance(20);
    a_valid = 2'b11; a_trap = 2'b10;
    @(negedge clk);
    total++; if (a_check !== 1'b1) begin bad++; $display("FAIL arb_check got=%b exp=1", a_check); end
    total++; if (a_onehot !== 2'b01) begin bad++; $display("FAIL arb_onehot got=%b exp=01", a_onehot); end
    total++; if (a_ctrap !== 1'b0) begin bad++; $display("FAIL arb_trap got=%b exp=0", a_ctrap); end
    @(posedge clk); #1;
    a_valid = 2'b00; a_trap = 2'b00;
    @(negedge clk);
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL arb_done got=%b exp=1", a_done); end
    total++; if (a_rcnt !== 8'd2) begin bad++; $display("FAIL arb_rcnt got=%0d exp=2", a_rcnt); end
    total++; if (a_tmo !== 1'b0) begin bad++; $display("FAIL arb_timeout got=%b exp=0", a_tmo); end
    // Upper channel only, with trap.
    reset_a(1'b1);
    advance(20);
    a_valid = 2'b10; a_trap = 2'b10;
    @(negedge clk);
    total++; if (a_onehot !== 2'b10) begin bad++; $display("FAIL arb2_onehot got=%b exp=10", a_onehot); end
    total++; if (a_ctrap !== 1'b1) begin bad++; $display("FAIL arb2_trap got=%b exp=1", a_ctrap); end
    @(posedge clk); #1;
    a_valid = 2'b00; a_trap = 2'b00;
    $display("test_arbitration done");
  endtask

  task automatic test_rollback_same_cycle();
    reset_a(1'b1);
    advance(20);
    a_valid = 2'b01; a_rb = 1'b1;
    @(negedge clk);
    total++; if (a_check !== 1'b0) begin bad++; $display("FAIL rbsame_check got=%b exp=0", a_check); end
    @(posedge clk); #1;
    a_rb = 1'b0;
    @(negedge clk);
    total++; if (a_check !== 1'b1) begin bad++; $display("FAIL rbsame_next got=%b exp=1", a_check); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rbsame_done0 got=%b exp=0", a_done); end
    @(posedge clk); #1;
    a_valid = 2'b00;
    @(negedge clk);
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL rbsame_done1 got=%b exp=1", a_done); end
    $display("test_rollback_same_cycle done");
  endtask

  // B arms at cycle 4. mode 0: plain skip; mode 1: rollback alone after two
  // retirements; mode 2: rollback together with a retirement after two.
  task automatic test_skip(input int mode);
    logic e_chk;
    int   fire_k;
    fire_k = (mode == 0) ? 7 : 10;
    reset_b();
    advance(4);
    for (int k = 4; k <= 11; k++) begin
      b_valid = (k <= 10) ? 1'b1 : 1'b0;
      b_rb    = 1'b0;
      if (mode != 0 && k == 6) begin
        b_rb    = 1'b1;
        b_valid = (mode == 2) ? 1'b1 : 1'b0;
      end
      @(negedge clk);
      e_chk = (k == fire_k);
      total++; if (b_check !== e_chk) begin bad++; $display("FAIL skip%0d_check k=%0d got=%b exp=%b", mode, k, b_check, e_chk); end
      @(posedge clk); #1;
    end
    b_valid = 1'b0; b_rb = 1'b0;
    @(negedge clk);
    total++; if (b_done !== 1'b1) begin bad++; $display("FAIL skip%0d_done got=%b exp=1", mode, b_done); end
    $display("test_skip mode=%0d done", mode);
  endtask

  task automatic test_timeout();
    logic       e_done;
    logic [4:0] e_cyc;
    reset_c();
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      e_done = (k >= 32);
      e_cyc  = (k > 31) ? 5'd31 : 5'(k);
      total++; if (c_cycle !== e_cyc) begin bad++; $display("FAIL tmo_cycle k=%0d got=%0d exp=%0d", k, c_cycle, e_cyc); end
      total++; if (c_done !== e_done) begin bad++; $display("FAIL tmo_done k=%0d got=%b exp=%b", k, c_done, e_done); end
      total++; if (c_tmo !== e_done) begin bad++; $display("FAIL tmo_timeout k=%0d got=%b exp=%b", k, c_tmo, e_done); end
      total++; if (c_check !== 1'b0) begin bad++; $display("FAIL tmo_check k=%0d got=%b exp=0", k, c_check); end
      @(posedge clk); #1;
    end
    $display("test_timeout done");
  endtask

  initial begin
    a_rst = 1'b1; a_en = 1'b1; a_valid = '0; a_trap = '0; a_rb = 1'b0;
    b_rst = 1'b1; b_en = 1'b1; b_valid = '0; b_trap = '0; b_rb = 1'b0;
    c_rst = 1'b1; c_en = 1'b1; c_valid = '0; c_trap = '0; c_rb = 1'b0;
    test_reset();
    test_single_channel();
    test_reset_mid_check();
    test_enable();
    test_arbitration();
    test_rollback_same_cycle();
    test_skip(0);
    test_skip(1);
    test_skip(2);
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
